seq_restoring_divider: RTL and testbench

//  Iterative unsigned restoring divider. Computes the inverse operation of the
//  8x8 Dadda multiplier: dividend / divisor -> quotient, remainder.

---
 rtl/seq_restoring_divider_pkg.sv | 13 +
 rtl/seq_restoring_divider_if.sv | 40 ++++
 rtl/seq_restoring_divider_div_step.sv | 30 +++
 rtl/seq_restoring_divider.sv | 133 +++++++++++++
 tb/tb_seq_restoring_divider.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_restoring_divider_pkg.sv
// Shared definitions for the sequential restoring divider:
// FSM state encodings and the default operand width.
package seq_div_pkg;

    localparam int DIV_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/seq_restoring_divider_if.sv
// Handshake/operand bundle for seq_restoring_divider.
// master = requester (drives operands/start), slave = divider.
// Optional macro SEQ_DIV_DZ_EN adds the dz_err divide-by-zero flag.
interface seq_restoring_divider_if #(
    parameter int WIDTH = seq_div_pkg::DIV_WIDTH
);

    logic             enable;
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
`ifdef SEQ_DIV_DZ_EN
    logic             dz_err;

    modport master (
        output enable, start, dividend, divisor,
        input  busy, done, quotient, remainder, dz_err
    );

    modport slave (
        input  enable, start, dividend, divisor,
        output busy, done, quotient, remainder, dz_err
    );
`else
    modport master (
        output enable, start, dividend, divisor,
        input  busy, done, quotient, remainder
    );

    modport slave (
        input  enable, start, dividend, divisor,
        output busy, done, quotient, remainder
    );
`endif

endinterface

// File: rtl/seq_restoring_divider_div_step.sv
// One combinational restoring-division step, MSB first.
// The shifted partial remainder is compared at WIDTH+1 bits; the stored
// remainder always fits in WIDTH bits because it stays below the divisor.
module div_step #(
    parameter int WIDTH = seq_div_pkg::DIV_WIDTH
) (
    input  logic [WIDTH-1:0] p,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] p_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0] p_sh;
    logic           ge;

    assign p_sh = {p, q[WIDTH-1]};
    assign ge   = (p_sh >= {1'b0, d});

    // shift in the next dividend bit, subtract when the divisor fits
    always_comb begin
        p_next = p_sh[WIDTH-1:0];
        q_next = {q[WIDTH-2:0], 1'b0};
        if (ge) begin
            p_next = p_sh[WIDTH-1:0] - d;
            q_next = {q[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// Start/busy/done handshake; enable low forces all outputs to 0 and aborts
// a running division.
// Optional macro SEQ_DIV_DZ_EN: divide-by-zero shortcut with dz_err flag.
//
// state   | meaning
// ST_IDLE | waiting for start & enable
// ST_RUN  | iterating, cnt counts steps 0..WIDTH-1
// ST_DONE | results valid, done pulse; may accept a new start
module seq_restoring_divider
    import seq_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    seq_restoring_divider_if.slave bus
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    div_state_t       state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] p_reg, q_reg, d_reg;
    logic [WIDTH-1:0] quo_reg, rem_reg;
    logic [WIDTH-1:0] p_nxt, q_nxt;
    logic             accept;
    logic             last_step;
    logic             dz_take;

    div_step #(.WIDTH(WIDTH)) u_step (
        .p      (p_reg),
        .q      (q_reg),
        .d      (d_reg),
        .p_next (p_nxt),
        .q_next (q_nxt)
    );

    assign last_step = (cnt == CW'(WIDTH - 1));

`ifdef SEQ_DIV_DZ_EN
    logic dz_reg;
    assign dz_take    = (bus.divisor == '0);
    assign bus.dz_err = bus.enable & dz_reg;
`else
    assign dz_take    = 1'b0;
`endif

    // state register
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // next-state and start acceptance
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.enable && bus.start) begin
                    accept    = 1'b1;
                    state_nxt = dz_take ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (!bus.enable)
                    state_nxt = ST_IDLE;
                else if (last_step)
                    state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (bus.enable && bus.start) begin
                    accept    = 1'b1;
                    state_nxt = dz_take ? ST_DONE : ST_RUN;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // operand capture, iteration registers and result registers
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            cnt     <= '0;
            p_reg   <= '0;
            q_reg   <= '0;
            d_reg   <= '0;
            quo_reg <= '0;
            rem_reg <= '0;
`ifdef SEQ_DIV_DZ_EN
            dz_reg  <= 1'b0;
`endif
        end else if (accept) begin
            cnt   <= '0;
            p_reg <= '0;
            q_reg <= bus.dividend;
            d_reg <= bus.divisor;
`ifdef SEQ_DIV_DZ_EN
            dz_reg <= dz_take;
            if (dz_take) begin
                quo_reg <= '1;
                rem_reg <= bus.dividend;
            end
`endif
        end else if (state == ST_RUN) begin
            if (!bus.enable) begin
                cnt     <= '0;
                quo_reg <= '0;
                rem_reg <= '0;
            end else begin
                p_reg <= p_nxt;
                q_reg <= q_nxt;
                cnt   <= cnt + 1'b1;
                if (last_step) begin
                    cnt     <= '0;
                    quo_reg <= q_nxt;
                    rem_reg <= p_nxt;
                end
            end
        end
    end

    assign bus.busy      = bus.enable & (state == ST_RUN);
    assign bus.done      = bus.enable & (state == ST_DONE);
    assign bus.quotient  = bus.enable ? quo_reg : '0;
    assign bus.remainder = bus.enable ? rem_reg : '0;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed bench for seq_restoring_divider: reset, latency, back-to-back,
// divide-by-zero, enable abort, edge values and a random sample vs a/b, a%b.
// Build with SEQ_DIV_DZ_EN defined to exercise the dz_err variant.
module tb_seq_restoring_divider;

    localparam int W = 8;
`ifdef SEQ_DIV_DZ_EN
    localparam int DZ_LAT = 1;
`else
    localparam int DZ_LAT = W + 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_chk  = 0;
    int n_pass = 0;

    seq_restoring_divider_if #(.WIDTH(W)) bus ();

    seq_restoring_divider #(.WIDTH(W)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // waits for done starting from the sample after the accept edge (lat=1)
    task automatic wait_done(inout int lat, inout int nb);
        while (!bus.done && lat < 40) begin
            if (bus.busy) nb++;
            tick();
            lat++;
        end
        if (!bus.done) lat = -1;
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output int lat, output int nb);
        bus.dividend = a;
        bus.divisor  = b;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        lat = 1;
        nb  = 0;
        wait_done(lat, nb);
        q = bus.quotient;
        r = bus.remainder;
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
    } vec_t;

    initial begin
        logic [W-1:0] q, r;
        int lat, nb, n_done, n_mis;
        vec_t edges[4];

        edges[0] = '{a: 8'd37,  b: 8'd1,   q: 8'd37, r: 8'd0};
        edges[1] = '{a: 8'd5,   b: 8'd200, q: 8'd0,  r: 8'd5};
        edges[2] = '{a: 8'hFF,  b: 8'hFF,  q: 8'd1,  r: 8'd0};
        edges[3] = '{a: 8'd0,   b: 8'd3,   q: 8'd0,  r: 8'd0};

        bus.enable   = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        #12;
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_q", 32'(bus.quotient), 0);
        chk("rst_r", 32'(bus.remainder), 0);
`ifdef SEQ_DIV_DZ_EN
        chk("rst_dz", 32'(bus.dz_err), 0);
`endif
        tick();
        rst = 1'b0;
        tick();

        // 200/7: busy for W cycles, done at T0+W+1 for one cycle
        do_op(8'd200, 8'd7, q, r, lat, nb);
        chk("lat_200_7", 32'(lat), W + 1);
        chk("busy_cnt_200_7", 32'(nb), W);
        chk("done_busy_low", 32'(bus.busy), 0);
        chk("q_200_7", 32'(q), 28);
        chk("r_200_7", 32'(r), 4);
        tick();
        chk("done_one_cycle", 32'(bus.done), 0);
        chk("q_hold", 32'(bus.quotient), 28);

        // reset asserted mid-run at T0+4
        bus.dividend = 8'd200;
        bus.divisor  = 8'd7;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(bus.busy), 0);
        chk("midrst_done", 32'(bus.done), 0);
        chk("midrst_q", 32'(bus.quotient), 0);
        chk("midrst_r", 32'(bus.remainder), 0);
        tick();
        rst = 1'b0;
        tick();
        chk("postrst_idle", 32'(bus.busy), 0);
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.done) n_done++;
            tick();
        end
        chk("postrst_no_done", 32'(n_done), 0);

        // back-to-back with an ignored start during busy
        bus.dividend = 8'd100;
        bus.divisor  = 8'd9;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        lat = 1;
        nb  = 0;
        tick();
        tick();
        lat = 3;
        bus.start    = 1'b1;
        bus.dividend = 8'd3;
        bus.divisor  = 8'd3;
        tick();
        bus.start = 1'b0;
        lat = 4;
        wait_done(lat, nb);
        chk("ign_lat", 32'(lat), W + 1);
        chk("ign_q", 32'(bus.quotient), 11);
        chk("ign_r", 32'(bus.remainder), 1);
        bus.dividend = 8'd255;
        bus.divisor  = 8'd16;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("b2b_busy", 32'(bus.busy), 1);
        lat = 1;
        nb  = 0;
        wait_done(lat, nb);
        chk("b2b_lat", 32'(lat), W + 1);
        chk("b2b_q", 32'(bus.quotient), 15);
        chk("b2b_r", 32'(bus.remainder), 15);
        tick();

        // divide by zero
        do_op(8'h5A, 8'd0, q, r, lat, nb);
        chk("dz_lat", 32'(lat), DZ_LAT);
        chk("dz_q", 32'(q), 32'hFF);
        chk("dz_r", 32'(r), 32'h5A);
`ifdef SEQ_DIV_DZ_EN
        chk("dz_flag", 32'(bus.dz_err), 1);
        tick();
        chk("dz_hold", 32'(bus.dz_err), 1);
        bus.dividend = 8'd9;
        bus.divisor  = 8'd2;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("dz_clear", 32'(bus.dz_err), 0);
        lat = 1;
        nb  = 0;
        wait_done(lat, nb);
        chk("dz_after_q", 32'(bus.quotient), 4);
`endif
        tick();

        // enable dropped at T0+3 aborts the run
        bus.dividend = 8'd200;
        bus.divisor  = 8'd7;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        bus.enable = 1'b0;
        #1;
        chk("en_busy", 32'(bus.busy), 0);
        chk("en_done", 32'(bus.done), 0);
        chk("en_q", 32'(bus.quotient), 0);
        chk("en_r", 32'(bus.remainder), 0);
        tick();
        bus.enable = 1'b1;
        #1;
        chk("abort_idle", 32'(bus.busy), 0);
        chk("abort_q_clr", 32'(bus.quotient), 0);
        chk("abort_r_clr", 32'(bus.remainder), 0);
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.done) n_done++;
            tick();
        end
        chk("abort_no_done", 32'(n_done), 0);

        // edge values
        foreach (edges[i]) begin
            do_op(edges[i].a, edges[i].b, q, r, lat, nb);
            chk("edge_q", 32'(q), 32'(edges[i].q));
            chk("edge_r", 32'(r), 32'(edges[i].r));
            tick();
        end

        // random-order sample against a/b, a%b
        n_mis = 0;
        for (int i = 0; i < 1200; i++) begin
            logic [W-1:0] a, b;
            a = W'($urandom_range(0, 255));
            b = W'($urandom_range(1, 255));
            do_op(a, b, q, r, lat, nb);
            if (lat != W + 1 || q !== a / b || r !== a % b) n_mis++;
        end
        chk("sweep_mismatches", 32'(n_mis), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
